pwm_scheduler: RTL and testbench

PWM_SCHEDULER -- requirements
Module: pwm_scheduler

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_scheduler_frame_timer.sv | 41 ++++
 rtl/pwm_scheduler.sv | 167 ++++++++++++++++
 tb/tb_pwm_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Brief    : Shared types and default constants for the PWM pattern scheduler
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int PWM_FRAME_LEN = 128;
    localparam int PWM_W         = 7;
    localparam int PWM_DEPTH     = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One pattern-table entry at the default value width
    typedef struct packed {
        logic [PWM_W-1:0] A;
        logic [PWM_W-1:0] B;
    } pwm_entry_t;

endpackage
`default_nettype wire

// File: rtl/pwm_scheduler_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_timer
//  Brief    : Free-running 0..FRAME_LEN-1 frame counter, held at 0 while idle;
//             tick marks the last cycle of each frame.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_timer
    import pwm_pkg::*;
#(
    parameter int FRAME_LEN = PWM_FRAME_LEN
) (
    input  logic clkCore,
    input  logic reset_b,
    input  logic run,
    output logic tick
);

    // A 1-bit counter is still needed when FRAME_LEN is 2
    localparam int            CW     = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] c_last = CW'(FRAME_LEN - 1);

    logic [CW-1:0] r_cnt;

    // Count while the sequencer is busy; restart from 0 whenever it idles
    always_ff @(posedge clkCore or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt <= '0;
        end else if (!run) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = run && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/pwm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_scheduler
//  Brief    : Steps a PWM generator through a 4-entry (A,B) pattern table,
//             dwelling a programmable number of frames on each entry, with
//             optional looping and a frame-aligned stop.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_scheduler
    import pwm_pkg::*;
#(
    parameter int FRAME_LEN = PWM_FRAME_LEN,
    parameter int W         = PWM_W,
    parameter int DEPTH     = PWM_DEPTH
) (
    input  logic         clkCore,
    input  logic         reset_b,
    input  logic         start,
    input  logic         stop,
    input  logic         loop,
    input  logic [1:0]   last_idx,
    input  logic [7:0]   dwell,
    input  logic         wr_en,
    input  logic [1:0]   wr_addr,
    input  logic [W-1:0] wr_A,
    input  logic [W-1:0] wr_B,
    output logic         en,
    output logic         load,
    output logic [W-1:0] A_val,
    output logic [W-1:0] B_val,
    output logic [1:0]   idx,
    output logic         busy,
    output logic         done
);

    // Pattern table
    logic [W-1:0] r_tab_a [DEPTH];
    logic [W-1:0] r_tab_b [DEPTH];

    // Sequencer state and parameters latched at start
    state_t       r_state;
    logic [1:0]   r_idx;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_load;
    logic         r_loop;
    logic [1:0]   r_last;
    logic [7:0]   r_dwell;
    logic [7:0]   r_dcnt;

    logic         w_run;
    logic         w_tick;
    logic [7:0]   w_dwell_top;
    logic         w_dwell_exp;
    logic [1:0]   w_next_idx;
    logic         w_final;

    assign w_run       = (r_state != IDLE);
    // A dwell of 0 behaves like 1: the entry is shown for a single frame
    assign w_dwell_top = (r_dwell == 8'd0) ? 8'd0 : (r_dwell - 8'd1);
    assign w_dwell_exp = (r_dcnt == w_dwell_top);
    assign w_next_idx  = r_idx + 2'd1;
    assign w_final     = w_dwell_exp && (r_idx == r_last) && !r_loop;

    frame_timer #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_timer (
        .clkCore (clkCore),
        .reset_b (reset_b),
        .run     (w_run),
        .tick    (w_tick)
    );

    // Table write port; reads elsewhere see the old contents on a write cycle
    always_ff @(posedge clkCore or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_a[i] <= '0;
                r_tab_b[i] <= '0;
            end
        end else if (wr_en) begin
            r_tab_a[wr_addr] <= wr_A;
            r_tab_b[wr_addr] <= wr_B;
        end
    end

    // Sequencer: start, per-frame dwell/advance/wrap, stop and drain
    always_ff @(posedge clkCore or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_a     <= '0;
            r_b     <= '0;
            r_load  <= 1'b0;
            r_loop  <= 1'b0;
            r_last  <= 2'd0;
            r_dwell <= 8'd0;
            r_dcnt  <= 8'd0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_idx   <= 2'd0;
                        r_dcnt  <= 8'd0;
                        r_a     <= r_tab_a[0];
                        r_b     <= r_tab_b[0];
                        r_load  <= 1'b1;
                        r_loop  <= loop;
                        r_last  <= last_idx;
                        r_dwell <= dwell;
                    end
                end
                RUN: begin
                    if (w_tick) begin
                        if (stop) begin
                            // Stop landing on the frame end finishes right away
                            r_state <= IDLE;
                        end else if (!w_dwell_exp) begin
                            r_dcnt <= r_dcnt + 8'd1;
                            r_a    <= r_tab_a[r_idx];
                            r_b    <= r_tab_b[r_idx];
                            r_load <= 1'b1;
                        end else if (r_idx != r_last) begin
                            r_idx  <= w_next_idx;
                            r_dcnt <= 8'd0;
                            r_a    <= r_tab_a[w_next_idx];
                            r_b    <= r_tab_b[w_next_idx];
                            r_load <= 1'b1;
                        end else if (r_loop) begin
                            r_idx  <= 2'd0;
                            r_dcnt <= 8'd0;
                            r_a    <= r_tab_a[0];
                            r_b    <= r_tab_b[0];
                            r_load <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (stop) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign en    = w_run;
    assign busy  = w_run;
    assign load  = r_load;
    assign A_val = r_a;
    assign B_val = r_b;
    assign idx   = r_idx;
    // Completion is flagged in the last cycle of the final frame, so it lines
    // up with the frame end; a coincident stop suppresses it
    assign done  = (r_state == RUN) && w_tick && w_final && !stop;

endmodule
`default_nettype wire

// File: tb/tb_pwm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_scheduler
//  Brief    : Self-checking bench for pwm_scheduler (FRAME_LEN = 8)
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_scheduler;
    import pwm_pkg::*;

    localparam int FL = 8;
    localparam int WW = 7;

    logic          clkCore = 1'b0;
    logic          reset_b = 1'b0;
    logic          start, stop, loop;
    logic [1:0]    last_idx;
    logic [7:0]    dwell;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [WW-1:0] wr_A, wr_B;
    logic          en, load, busy, done;
    logic [WW-1:0] A_val, B_val;
    logic [1:0]    idx;

    pwm_scheduler #(.FRAME_LEN(FL), .W(WW), .DEPTH(4)) dut (
        .clkCore(clkCore), .reset_b(reset_b), .start(start), .stop(stop),
        .loop(loop), .last_idx(last_idx), .dwell(dwell), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_A(wr_A), .wr_B(wr_B), .en(en), .load(load),
        .A_val(A_val), .B_val(B_val), .idx(idx), .busy(busy), .done(done)
    );

    always #5 clkCore = ~clkCore;

    int cyc = 0;
    always @(posedge clkCore) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [WW-1:0] a;
        logic [WW-1:0] b;
        logic [1:0]    ix;
    } ld_t;

    typedef struct {
        logic       lp;
        logic [1:0] li;
        logic [7:0] dw;
        int         frames;
        int         done_at;   // 1-based cycle (first load = 1); 0 = loops
    } vec_t;

    ld_t        ld_q[$];
    int         done_q[$];
    pwm_entry_t tab[4];
    int         tests = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;
    logic [WW-1:0] prev_a = '0, prev_b = '0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every load and done must match the next expectation
    always @(negedge clkCore) begin
        ld_t e;
        if (mon_en) begin
            if (load) begin
                if (ld_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_load: got load=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = ld_q.pop_front();
                    chk("load_cycle", cyc, e.cyc);
                    chk("load_A", 32'(A_val), 32'(e.a));
                    chk("load_B", 32'(B_val), 32'(e.b));
                    chk("load_idx", 32'(idx), 32'(e.ix));
                end
            end else if (A_val !== prev_a || B_val !== prev_b) begin
                tests++; fails++;
                $display("FAIL ab_hold: got A=%0d B=%0d expected A=%0d B=%0d without load (cycle %0d)",
                         A_val, B_val, prev_a, prev_b, cyc);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
        prev_a = A_val;
        prev_b = B_val;
    end

    task automatic step();
        @(posedge clkCore);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [WW-1:0] va, input logic [WW-1:0] vb);
        wr_en = 1'b1; wr_addr = a; wr_A = va; wr_B = vb;
        step();
        wr_en = 1'b0;
        tab[a] = '{A: va, B: vb};
    endtask

    // Pulse start; s is the cycle in which the first load is visible
    task automatic start_seq(input logic lp, input logic [1:0] li, input logic [7:0] dw,
                             input logic with_stop, output int s);
        loop = lp; last_idx = li; dwell = dw; start = 1'b1; stop = with_stop;
        step();
        s = cyc;
        start = 1'b0; stop = 1'b0;
        loop = ~lp; last_idx = ~li; dwell = ~dw;
    endtask

    // Expected load stream of a sequence, one entry per frame
    task automatic push_model(input int s, input logic [1:0] li, input logic [7:0] dw, input int frames);
        int i = 0;
        int d = 0;
        int dmax = (dw == 8'd0) ? 1 : int'(dw);
        for (int k = 0; k < frames; k++) begin
            ld_q.push_back(ld_t'{s + FL * k, tab[i].A, tab[i].B, 2'(i)});
            d++;
            if (d == dmax) begin
                d = 0;
                i = (i == int'(li)) ? 0 : i + 1;
            end
        end
    endtask

    task automatic drain_check(input string n);
        repeat (3) step();
        chk({n, "_loads_left"}, ld_q.size(), 0);
        chk({n, "_dones_left"}, done_q.size(), 0);
        ld_q.delete();
        done_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   s;
        vecs[0] = '{1'b0, 2'd2, 8'd2, 6, 48};
        vecs[1] = '{1'b1, 2'd2, 8'd0, 5, 0};
        vecs[2] = '{1'b0, 2'd0, 8'd0, 1, 8};
        vecs[3] = '{1'b0, 2'd1, 8'd3, 6, 48};
        vecs[4] = '{1'b0, 2'd3, 8'd1, 4, 32};
        vecs[5] = '{1'b1, 2'd1, 8'd2, 6, 0};

        start = 0; stop = 0; loop = 0; last_idx = 0; dwell = 0;
        wr_en = 0; wr_addr = 0; wr_A = 0; wr_B = 0;
        for (int i = 0; i < 4; i++) tab[i] = '{A: '0, B: '0};

        // Reset state
        repeat (2) step();
        chk1("rst_en", en, 1'b0);
        chk1("rst_load", load, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_A", 32'(A_val), 0);
        chk("rst_B", 32'(B_val), 0);
        reset_b = 1'b1;
        step();

        wr(2'd0, 7'd1, 7'd2);
        wr(2'd1, 7'd3, 7'd4);
        wr(2'd2, 7'd5, 7'd6);
        wr(2'd3, 7'd11, 7'd12);
        mon_en = 1'b1;

        // Stop in IDLE is ignored
        stop = 1'b1; step(); stop = 1'b0;
        @(negedge clkCore);
        chk1("idle_stop_busy", busy, 1'b0);

        // Table-driven sequences
        for (int v = 0; v < 6; v++) begin
            start_seq(vecs[v].lp, vecs[v].li, vecs[v].dw, 1'b0, s);
            push_model(s, vecs[v].li, vecs[v].dw, vecs[v].frames);
            if (!vecs[v].lp) begin
                done_q.push_back(s - 1 + vecs[v].done_at);
                wait_until(s - 1 + vecs[v].done_at);
                @(negedge clkCore);
                chk1("vec_busy_last", busy, 1'b1);
                step();
                @(negedge clkCore);
                chk1("vec_busy_after", busy, 1'b0);
                chk1("vec_en_after", en, 1'b0);
            end else begin
                wait_until(s - 1 + FL * vecs[v].frames);
                stop = 1'b1; step(); stop = 1'b0;
                @(negedge clkCore);
                chk1("vec_stop_busy", busy, 1'b0);
                chk1("vec_stop_load", load, 1'b0);
            end
            drain_check("vec");
        end

        // Stop mid-frame drains to the frame end; stop in DRAIN ignored
        start_seq(1'b1, 2'd2, 8'd0, 1'b0, s);
        push_model(s, 2'd2, 8'd0, 1);
        wait_until(s + 3);
        stop = 1'b1; step(); stop = 1'b0;
        wait_until(s + 5);
        stop = 1'b1; step(); stop = 1'b0;
        wait_until(s + 7);
        @(negedge clkCore);
        chk1("drain_busy_end", busy, 1'b1);
        chk1("drain_en_end", en, 1'b1);
        step();
        @(negedge clkCore);
        chk1("drain_busy_after", busy, 1'b0);
        chk1("drain_en_after", en, 1'b0);
        drain_check("drain");

        // Same-cycle write at the boundary loading entry 1 returns old data
        start_seq(1'b1, 2'd2, 8'd0, 1'b0, s);
        ld_q.push_back(ld_t'{s,      7'd1, 7'd2, 2'd0});
        ld_q.push_back(ld_t'{s + 8,  7'd3, 7'd4, 2'd1});
        ld_q.push_back(ld_t'{s + 16, 7'd5, 7'd6, 2'd2});
        ld_q.push_back(ld_t'{s + 24, 7'd1, 7'd2, 2'd0});
        ld_q.push_back(ld_t'{s + 32, 7'd7, 7'd7, 2'd1});
        wait_until(s + 7);
        wr_en = 1'b1; wr_addr = 2'd1; wr_A = 7'd7; wr_B = 7'd7;
        step();
        wr_en = 1'b0;
        wait_until(s + 39);
        stop = 1'b1; step(); stop = 1'b0;
        @(negedge clkCore);
        chk1("wr_stop_busy", busy, 1'b0);
        drain_check("wr");
        wr(2'd1, 7'd3, 7'd4);

        // start+stop together in IDLE starts; start while busy is ignored
        start_seq(1'b0, 2'd1, 8'd1, 1'b1, s);
        push_model(s, 2'd1, 8'd1, 2);
        done_q.push_back(s + 15);
        wait_until(s + 4);
        start = 1'b1; loop = 1'b1; last_idx = 2'd0; dwell = 8'd9;
        step();
        start = 1'b0;
        wait_until(s + 12);
        start = 1'b1; step(); start = 1'b0;
        wait_until(s + 15);
        @(negedge clkCore);
        chk1("restart_busy_last", busy, 1'b1);
        step();
        @(negedge clkCore);
        chk1("restart_busy_after", busy, 1'b0);
        drain_check("restart");

        // Asynchronous reset mid-sequence clears outputs and table
        wr(2'd0, 7'd5, 7'd9);
        start_seq(1'b1, 2'd0, 8'd0, 1'b0, s);
        push_model(s, 2'd0, 8'd0, 2);
        wait_until(s + 10);
        chk("prereset_A", 32'(A_val), 5);
        mon_en = 1'b0;
        #2 reset_b = 1'b0;
        #1;
        chk1("arst_en", en, 1'b0);
        chk1("arst_load", load, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_done", done, 1'b0);
        chk("arst_idx", 32'(idx), 0);
        chk("arst_A", 32'(A_val), 0);
        chk("arst_B", 32'(B_val), 0);
        step();
        reset_b = 1'b1;
        ld_q.delete();
        done_q.delete();
        for (int i = 0; i < 4; i++) tab[i] = '{A: '0, B: '0};
        @(negedge clkCore);
        mon_en = 1'b1;
        start_seq(1'b0, 2'd0, 8'd0, 1'b0, s);
        push_model(s, 2'd0, 8'd0, 1);
        done_q.push_back(s + 7);
        wait_until(s + 8);
        @(negedge clkCore);
        chk1("post_rst_busy", busy, 1'b0);
        drain_check("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
